// File: rtl/sysid_reader.sv
// sysid_reader: reads the system ID (word 0) and build timestamp (word 1)
// from an Avalon-MM slave on request, compares both against the values this
// build expects and reports match / timeout with a one-cycle done pulse.
// A per-read stall counter aborts a read whose slave holds waitrequest
// for TIMEOUT_CYCLES cycles; TIMEOUT_CYCLES = 0 lets a read stall forever.
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1319521005,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        timeout
);

  // Wide enough to hold TIMEOUT_CYCLES itself, so the count never wraps.
  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] stall_cnt;

  // Control strobes from the FSM to the datapath registers.
  logic stall_clr;
  logic stall_inc;
  logic clr_flags;
  logic cap_id;
  logic cap_ts;
  logic set_timeout;
  logic do_check;

  // This stalled cycle is the one that brings the count to the limit.
  logic stall_limit;
  assign stall_limit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(stall_cnt) + 32'd1) == TIMEOUT_CYCLES);

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode, bus outputs and datapath strobes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_next  = state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    stall_clr   = 1'b0;
    stall_inc   = 1'b0;
    clr_flags   = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    set_timeout = 1'b0;
    do_check    = 1'b0;

    case (state)
      IDLE: begin
        busy      = 1'b0;
        stall_clr = 1'b1;
        if (start) begin
          clr_flags  = 1'b1;
          state_next = RD_ID;
        end
      end

      RD_ID: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          cap_id     = 1'b1;
          stall_clr  = 1'b1;       // fresh budget for the timestamp read
          state_next = RD_TS;
        end else begin
          stall_inc = 1'b1;
          if (stall_limit) begin
            set_timeout = 1'b1;
            state_next  = DONE;
          end
        end
      end

      RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        if (!avm_waitrequest) begin
          cap_ts     = 1'b1;
          state_next = CHECK;
        end else begin
          stall_inc = 1'b1;
          if (stall_limit) begin
            set_timeout = 1'b1;
            state_next  = DONE;
          end
        end
      end

      CHECK: begin
        do_check   = 1'b1;
        state_next = DONE;
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stall counter, captured words and result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt       <= '0;
      id_value        <= '0;
      timestamp_value <= '0;
      match           <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      if (stall_clr) begin
        stall_cnt <= '0;
      end else if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      if (clr_flags) begin
        match   <= 1'b0;
        timeout <= 1'b0;
      end

      if (cap_id) id_value        <= avm_readdata;
      if (cap_ts) timestamp_value <= avm_readdata;

      if (set_timeout) begin
        timeout <= 1'b1;
        match   <= 1'b0;
      end

      if (do_check) begin
        match <= (id_value == EXPECTED_ID) &&
                 (timestamp_value == EXPECTED_TIMESTAMP);
      end
    end
  end

endmodule

// File: tb/tb_sysid_reader.sv
// Testbench for sysid_reader: a small Avalon slave with programmable stall
// counts answers the reads; the expected per-cycle timeline and end results
// come from a transaction-level model of the read/check sequence.
module tb_sysid_reader;

  localparam int unsigned T       = 4;
  localparam logic [31:0] GOOD_ID = 32'd0;
  localparam logic [31:0] GOOD_TS = 32'd1319521005;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] id_value;
  logic [31:0] timestamp_value;
  logic        busy;
  logic        done;
  logic        match;
  logic        timeout;

  always #5 clock = ~clock;

  sysid_reader #(
    .EXPECTED_ID       (GOOD_ID),
    .EXPECTED_TIMESTAMP(GOOD_TS),
    .TIMEOUT_CYCLES    (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .id_value       (id_value),
    .timestamp_value(timestamp_value),
    .busy           (busy),
    .done           (done),
    .match          (match),
    .timeout        (timeout)
  );

  int checks = 0;
  int errors = 0;

  // Slave configuration: data per word address and stall cycles per read.
  logic [31:0] slv_data  [2];
  int          slv_stall [2];
  int          slv_used  [2];

  // Model of the registered results as seen after a sequence completes.
  logic [31:0] m_id      = 32'd0;
  logic [31:0] m_ts      = 32'd0;
  logic        m_match   = 1'b0;
  logic        m_timeout = 1'b0;

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive slave inputs for the upcoming edge from the current bus request.
  // While stalling, readdata carries junk so a premature capture shows up.
  task automatic slave_drive();
    int a;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'hDEAD_BEEF;
    if (avm_read === 1'b1) begin
      a = (avm_address === 1'b1) ? 1 : 0;
      if (slv_used[a] < slv_stall[a]) begin
        avm_waitrequest = 1'b1;
        avm_readdata    = ~slv_data[a];
        slv_used[a]++;
      end else begin
        avm_readdata = slv_data[a];
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check1 ($sformatf("%s/read", tag),    avm_read,        1'b0);
    check1 ($sformatf("%s/addr", tag),    avm_address,     1'b0);
    check1 ($sformatf("%s/busy", tag),    busy,            1'b0);
    check1 ($sformatf("%s/done", tag),    done,            1'b0);
    check1 ($sformatf("%s/match", tag),   match,           1'b0);
    check1 ($sformatf("%s/timeout", tag), timeout,         1'b0);
    check32($sformatf("%s/id", tag),      id_value,        32'd0);
    check32($sformatf("%s/ts", tag),      timestamp_value, 32'd0);
  endtask

  // One start pulse and a full sequence. Cycle 1 is the cycle after the
  // edge that samples start. extra_at > 0 re-asserts start in that cycle,
  // which must be ignored because the block is busy.
  task automatic run_seq(input logic [31:0] id_d, input logic [31:0] ts_d,
                         input int sid, input int sts, input int extra_at,
                         input string tag);
    bit          id_to, ts_to;
    int          id_cyc, ts_cyc, done_cyc;
    logic [31:0] f_id, f_ts;
    logic        f_match, f_timeout;
    logic [3:0]  exp_vec;

    // A read with >= T stalls is abandoned after exactly T stalled cycles.
    id_to  = (sid >= int'(T));
    id_cyc = id_to ? int'(T) : sid + 1;
    ts_to  = !id_to && (sts >= int'(T));
    ts_cyc = id_to ? 0 : (ts_to ? int'(T) : sts + 1);
    if (id_to || ts_to) done_cyc = id_cyc + ts_cyc + 1;
    else                done_cyc = id_cyc + ts_cyc + 2;

    f_id      = id_to ? m_id : id_d;
    f_ts      = (id_to || ts_to) ? m_ts : ts_d;
    f_timeout = id_to || ts_to;
    f_match   = !f_timeout && (f_id == GOOD_ID) && (f_ts == GOOD_TS);

    slv_data[0]  = id_d;
    slv_data[1]  = ts_d;
    slv_stall[0] = sid;
    slv_stall[1] = sts;
    slv_used[0]  = 0;
    slv_used[1]  = 0;

    start = 1'b1;
    slave_drive();
    @(negedge clock);
    start = 1'b0;

    for (int c = 1; c <= done_cyc + 2; c++) begin
      // {avm_read, avm_address, busy, done}
      if (c <= id_cyc)                 exp_vec = 4'b1010;
      else if (c <= id_cyc + ts_cyc)   exp_vec = 4'b1110;
      else if (c < done_cyc)           exp_vec = 4'b0010;
      else if (c == done_cyc)          exp_vec = 4'b0011;
      else                             exp_vec = 4'b0000;
      check32($sformatf("%s/c%0d/bus", tag, c),
              {28'd0, avm_read, avm_address, busy, done}, {28'd0, exp_vec});
      if (c < done_cyc) begin
        check1($sformatf("%s/c%0d/match_clr", tag, c),   match,   1'b0);
        check1($sformatf("%s/c%0d/timeout_clr", tag, c), timeout, 1'b0);
      end else begin
        check1 ($sformatf("%s/c%0d/match", tag, c),   match,           f_match);
        check1 ($sformatf("%s/c%0d/timeout", tag, c), timeout,         f_timeout);
        check32($sformatf("%s/c%0d/id", tag, c),      id_value,        f_id);
        check32($sformatf("%s/c%0d/ts", tag, c),      timestamp_value, f_ts);
      end
      slave_drive();
      start = (c == extra_at);
      @(negedge clock);
    end
    start = 1'b0;

    m_id      = f_id;
    m_ts      = f_ts;
    m_match   = f_match;
    m_timeout = f_timeout;
  endtask

  initial begin
    logic [31:0] rid, rts;
    int          rsid, rsts, rextra;

    reset           = 1'b1;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    for (int i = 0; i < 2; i++) begin
      slv_data[i]  = 32'd0;
      slv_stall[i] = 0;
      slv_used[i]  = 0;
    end

    // Reset state, and start ignored while reset is held.
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check1("reset_over_start/busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    check1("idle/busy", busy, 1'b0);

    // Directed sequences.
    run_seq(GOOD_ID, GOOD_TS, 0, 0, 0, "zero_wait");
    run_seq(32'h1,   GOOD_TS, 0, 0, 0, "bad_id");
    run_seq(GOOD_ID, GOOD_TS, 3, 3, 0, "stall3");
    run_seq(GOOD_ID, 32'h1,   0, 0, 0, "bad_ts");
    run_seq(GOOD_ID, GOOD_TS, 3, 0, 0, "stall_under_limit");
    run_seq(32'h55,  32'h66, 20, 0, 2, "timeout_id");
    run_seq(GOOD_ID, GOOD_TS, 0, 4, 0, "timeout_ts");
    run_seq(GOOD_ID, GOOD_TS, 0, 0, 0, "recover");

    // Reset while the timestamp read is stalled.
    slv_data[0]  = 32'h1234;
    slv_data[1]  = GOOD_TS;
    slv_stall[0] = 0;
    slv_stall[1] = 100;
    slv_used[0]  = 0;
    slv_used[1]  = 0;
    start = 1'b1;
    slave_drive();
    @(negedge clock);
    start = 1'b0;
    check32("rst_mid/c1", {30'd0, avm_read, avm_address}, 32'd2);
    slave_drive();
    @(negedge clock);
    check32("rst_mid/c2", {30'd0, avm_read, avm_address}, 32'd3);
    check32("rst_mid/id_captured", id_value, 32'h1234);
    slave_drive();
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("rst_mid");
    reset     = 1'b0;
    m_id      = 32'd0;
    m_ts      = 32'd0;
    m_match   = 1'b0;
    m_timeout = 1'b0;
    slave_drive();
    @(negedge clock);
    run_seq(GOOD_ID, GOOD_TS, 1, 2, 0, "after_reset");

    // Randomized sequences: mostly-good words, varying stalls and stray starts.
    for (int n = 0; n < 20; n++) begin
      rid    = ($urandom_range(0, 2) == 0) ? $urandom : GOOD_ID;
      rts    = ($urandom_range(0, 2) == 0) ? $urandom : GOOD_TS;
      rsid   = int'($urandom_range(0, 5));
      rsts   = int'($urandom_range(0, 5));
      rextra = int'($urandom_range(0, 3));
      run_seq(rid, rts, rsid, rsts, rextra, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
